johnson_phase_monitor: RTL and testbench

- Sits directly downstream of the 5-bit Johnson counter and samples its stage outputs each clock.
- Decodes the thermometer code to a binary phase index and a one-hot phase bus.
- Checks that the counter only holds or advances by one legal step per sample.
- Counts completed revolutions and raises sticky error flags on illegal codes or skipped phases. Consumers are phase-gated control logic and the lab status display.

---
 rtl/johnson_phase_monitor.sv | 118 +++++++++++
 tb/tb_johnson_phase_monitor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_monitor.sv
// Samples a Johnson counter's stages, decodes the phase, checks each step is a
// hold or a single advance, counts revolutions and keeps sticky error flags.
module johnson_phase_monitor #(
  parameter int WIDTH = 5,
  parameter int PW    = 4,
  parameter int REV_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 err_clr,
  output logic [PW-1:0]        phase,
  output logic [2*WIDTH-1:0]   phase_onehot,
  output logic                 phase_valid,
  output logic                 wrap_pulse,
  output logic [REV_W-1:0]     rev_count,
  output logic                 illegal_err,
  output logic                 seq_err
);
  localparam int SEQ = 2 * WIDTH;

  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state;

  // Phases 0..N fill ones from stage 0 upward; phases N+1..2N-1 drain them
  // from stage 0, leaving ones only at stages p-N and above.
  function automatic logic [WIDTH-1:0] code_of(input int p);
    logic [WIDTH-1:0] c;
    for (int i = 0; i < WIDTH; i++)
      c[i] = (p <= WIDTH) ? (i < p) : (i >= p - WIDTH);
    return c;
  endfunction

  function automatic logic [SEQ-1:0] oh_of(input logic [PW-1:0] p);
    logic [SEQ-1:0] o;
    o = '0;
    o[p] = 1'b1;
    return o;
  endfunction

  logic          legal;
  logic [PW-1:0] dec;
  logic [PW-1:0] nxt;
  logic          last;

  always_comb begin
    legal = 1'b0;
    dec   = '0;
    for (int p = 0; p < SEQ; p++) begin
      if (q_in == code_of(p)) begin
        legal = 1'b1;
        dec   = PW'(p);
      end
    end
  end

  assign last = (phase == PW'(SEQ - 1));
  assign nxt  = last ? '0 : phase + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= UNLOCKED;
      phase        <= '0;
      phase_onehot <= '0;
      phase_valid  <= 1'b0;
      wrap_pulse   <= 1'b0;
      rev_count    <= '0;
      illegal_err  <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      // Clear first so a same-cycle detection below overrides it.
      if (err_clr) begin
        illegal_err <= 1'b0;
        seq_err     <= 1'b0;
      end
      if (en) begin
        case (state)
          UNLOCKED: begin
            if (legal) begin
              phase        <= dec;
              phase_onehot <= oh_of(dec);
              phase_valid  <= 1'b1;
              state        <= LOCKED;
            end else begin
              illegal_err  <= 1'b1;
              phase_valid  <= 1'b0;
              phase_onehot <= '0;
            end
          end
          LOCKED: begin
            if (!legal) begin
              illegal_err  <= 1'b1;
              phase_valid  <= 1'b0;
              phase_onehot <= '0;
              state        <= UNLOCKED;
            end else if (dec == nxt) begin
              phase        <= dec;
              phase_onehot <= oh_of(dec);
              if (last) begin
                wrap_pulse <= 1'b1;
                rev_count  <= rev_count + 1'b1;
              end
            end else if (dec != phase) begin
              seq_err      <= 1'b1;
              phase        <= dec;
              phase_valid  <= 1'b0;
              phase_onehot <= '0;
              state        <= UNLOCKED;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor; codes are written q_in[0..4] left to right.
module tb_johnson_phase_monitor;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [4:0] q_in = '0;
  logic       err_clr = 1'b0;
  logic [3:0] phase;
  logic [9:0] phase_onehot;
  logic       phase_valid, wrap_pulse, illegal_err, seq_err;
  logic [7:0] rev_count;

  int n_chk = 0;
  int n_fail = 0;

  logic [4:0] seq [10] = '{5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110,
                           5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001};

  johnson_phase_monitor dut (
    .clock(clock), .reset(reset), .en(en), .q_in(q_in), .err_clr(err_clr),
    .phase(phase), .phase_onehot(phase_onehot), .phase_valid(phase_valid),
    .wrap_pulse(wrap_pulse), .rev_count(rev_count),
    .illegal_err(illegal_err), .seq_err(seq_err)
  );

  always #5 clock = ~clock;

  // Spec notation lists q_in[0] first; flip into vector order.
  function automatic logic [4:0] rv(input logic [4:0] s);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = s[4-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [4:0] code, input logic e, input logic clr);
    q_in = rv(code);
    en = e;
    err_clr = clr;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".phase"}, 32'(phase), 0);
    chk({tag, ".onehot"}, 32'(phase_onehot), 0);
    chk({tag, ".valid"}, 32'(phase_valid), 0);
    chk({tag, ".wrap"}, 32'(wrap_pulse), 0);
    chk({tag, ".rev"}, 32'(rev_count), 0);
    chk({tag, ".ill"}, 32'(illegal_err), 0);
    chk({tag, ".seq"}, 32'(seq_err), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk_zero("rst");
    @(negedge clock);
    reset = 1'b0;

    // full revolution plus return to 0
    for (int i = 0; i <= 10; i++) begin
      step(seq[i % 10], 1'b1, 1'b0);
      chk($sformatf("rev.phase%0d", i), 32'(phase), 32'(i % 10));
      chk($sformatf("rev.valid%0d", i), 32'(phase_valid), 1);
      chk($sformatf("rev.wrap%0d", i), 32'(wrap_pulse), (i == 10) ? 1 : 0);
    end
    chk("rev.onehot0", 32'(phase_onehot), 32'h001);
    chk("rev.count", 32'(rev_count), 1);
    chk("rev.ill", 32'(illegal_err), 0);
    chk("rev.seq", 32'(seq_err), 0);
    step(5'b00000, 1'b1, 1'b0);
    chk("rev.wrap_once", 32'(wrap_pulse), 0);

    // hold with an en=0 gap
    do_reset();
    step(5'b11000, 1'b1, 1'b0);
    chk("hold.lock", 32'(phase), 2);
    step(5'b11100, 1'b1, 1'b0);
    step(5'b11100, 1'b0, 1'b0);
    chk("hold.en0", 32'(phase), 3);
    step(5'b11100, 1'b1, 1'b0);
    step(5'b11100, 1'b1, 1'b0);
    chk("hold.phase", 32'(phase), 3);
    chk("hold.onehot", 32'(phase_onehot), 32'h008);
    chk("hold.valid", 32'(phase_valid), 1);
    chk("hold.ill", 32'(illegal_err), 0);
    chk("hold.seq", 32'(seq_err), 0);

    // skipped phase
    do_reset();
    step(5'b11000, 1'b1, 1'b0);
    step(5'b11110, 1'b1, 1'b0);
    chk("skip.seq", 32'(seq_err), 1);
    chk("skip.valid", 32'(phase_valid), 0);
    chk("skip.phase", 32'(phase), 4);
    chk("skip.onehot", 32'(phase_onehot), 0);
    step(5'b11111, 1'b1, 1'b0);
    chk("relock.valid", 32'(phase_valid), 1);
    chk("relock.phase", 32'(phase), 5);
    chk("relock.onehot", 32'(phase_onehot), 32'h020);
    chk("relock.ill", 32'(illegal_err), 0);
    chk("relock.seq", 32'(seq_err), 1);

    // illegal code while locked
    do_reset();
    step(5'b10000, 1'b1, 1'b0);
    step(5'b10100, 1'b1, 1'b0);
    chk("ill.err", 32'(illegal_err), 1);
    chk("ill.phase", 32'(phase), 1);
    chk("ill.valid", 32'(phase_valid), 0);
    chk("ill.onehot", 32'(phase_onehot), 0);
    chk("ill.seq", 32'(seq_err), 0);

    // clear vs set priority, then clear alone
    step(5'b01010, 1'b1, 1'b1);
    chk("clr.setwins", 32'(illegal_err), 1);
    step(5'b10000, 1'b1, 1'b1);
    chk("clr.alone", 32'(illegal_err), 0);
    chk("clr.relock", 32'(phase_valid), 1);

    // 256 revolutions wrap the counter
    do_reset();
    step(5'b00000, 1'b1, 1'b0);
    chk("wrap.nowrap_on_lock", 32'(wrap_pulse), 0);
    for (int r = 0; r < 256; r++) begin
      for (int i = 1; i <= 10; i++) step(seq[i % 10], 1'b1, 1'b0);
      if (r == 254) chk("wrap.rev255", 32'(rev_count), 255);
    end
    chk("wrap.rev0", 32'(rev_count), 0);
    chk("wrap.pulse", 32'(wrap_pulse), 1);
    chk("wrap.valid", 32'(phase_valid), 1);

    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk_zero("arst");
    @(negedge clock);
    reset = 1'b0;
    step(5'b11100, 1'b1, 1'b0);
    chk("arst.relock_phase", 32'(phase), 3);
    chk("arst.relock_valid", 32'(phase_valid), 1);
    chk("arst.seq", 32'(seq_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
